instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
- REQ-001 SHALL have parameter QueueDepth, default 4, number of fetched-instruction queue entries (power of two, >= 2).
- REQ-002 SHALL have parameter ResetPC, default 32'h0, PC value loaded on reset.
- REQ-003 SHALL have port clk_in, input, 1, the single clock, rising-edge active.
- REQ-004 SHALL have port rst_n_in, input, 1, reset, asynchronous, active-low.
- REQ-005 SHALL have port rdy_in, input, 1, global enable; all state frozen when low.
- REQ-006 SHALL have port if_icache_inst_addr_out, output, 32, fetch address driven to the icache.
- REQ-007 SHALL have port icache_if_miss_in, input, 1, icache miss or busy; when low, the instruction is valid this cycle.
- REQ-008 SHALL have port icache_if_inst_inst_in, input, 32, instruction word for if_icache_inst_addr_out.
- REQ-009 SHALL have port if_dec_valid_out, output, 1, queue head valid.
- REQ-010 SHALL have port if_dec_inst_out, output, 32, queue head instruction.
- REQ-011 SHALL have port if_dec_pc_out, output, 32, queue head PC.
- REQ-012 SHALL have port dec_if_ready_in, input, 1, decoder accepts the head this cycle.
- REQ-013 SHALL have port rob_if_jump_en_in, input, 1, redirect/flush request.
- REQ-014 SHALL have port rob_if_jump_addr_in, input, 32, redirect target PC.

Function
- REQ-015 SHALL drive if_icache_inst_addr_out combinationally from the pc register at all times.
- REQ-016 SHALL hold pc constant while icache_if_miss_in is high, so the icache refill address stays stable.
- REQ-017 SHALL enqueue {pc, icache_if_inst_inst_in} and advance pc in the same cycle only when rdy_in=1, icache_if_miss_in=0, count<QueueDepth and rob_if_jump_en_in=0; fetch-to-visible latency is one cycle.
- REQ-018 SHALL block enqueue when count==QueueDepth, even if a dequeue occurs in the same cycle, using the registered count.
- REQ-019 SHALL drive if_dec_valid_out = (count!=0), with if_dec_inst_out and if_dec_pc_out read combinationally from the head entry.
- REQ-020 SHALL dequeue when rdy_in=1, if_dec_valid_out=1 and dec_if_ready_in=1; simultaneous enqueue and dequeue leave count unchanged.
- REQ-021 SHALL wrap head and tail pointers modulo QueueDepth; count width SHALL be log2(QueueDepth)+1.
- REQ-022 SHALL, when rob_if_jump_en_in=1 with rdy_in=1, clear count, head and tail, set pc to rob_if_jump_addr_in, and discard that cycle's enqueue and dequeue; redirect has priority over all other events.
- REQ-023 SHALL honour a redirect during an icache miss by updating pc immediately; the icache returns miss until it reaches the new address.
- REQ-024 SHALL compute the next pc as pc+4 with 32-bit wrap-around (32'hFFFFFFFC advances to 32'h0).

Reset
- REQ-025 SHALL, while rst_n_in=0 (asynchronous to clk_in), set pc=ResetPC, count=0, head=0 and tail=0, giving if_dec_valid_out=0 and if_icache_inst_addr_out=ResetPC.
- REQ-026 SHALL leave queue data contents unreset; they are not observable while count=0.
- REQ-027 SHALL resume fetching on the first rising edge after rst_n_in deasserts, given rdy_in=1.

Configuration
- REQ-028 SHALL, with macro IF_STATIC_PREDICT_EN defined, predict JAL as taken: when an enqueued instruction has opcode 7'b1101111, next pc = pc + sign-extended J-immediate; all other instructions use pc+4.
- REQ-029 SHALL, without IF_STATIC_PREDICT_EN, always use next pc = pc+4 and contain no immediate-decode logic.

Verification
- REQ-030 SHALL pass this scenario: reset, icache hit every cycle with decoder ready -> addresses 0x0, 0x4, 0x8 fetched on consecutive cycles; head pc 0x0 is visible one cycle after the first fetch.
- REQ-031 SHALL pass this scenario: decoder not ready for 6 cycles with hits -> count saturates at 4, pc stalls at 0x10 and if_icache_inst_addr_out stays 0x10.
- REQ-032 SHALL pass this scenario: miss held high for 10 cycles at pc 0x20 -> address stays 0x20 and no enqueue; miss falls -> 0x20 is enqueued and pc becomes 0x24.
- REQ-033 SHALL pass this scenario: redirect to 0x100 with 3 entries queued and a same-cycle hit -> next cycle valid=0, count=0 and address 0x100.
- REQ-034 SHALL pass this scenario: rdy_in low for 5 cycles mid-stream -> pc, count and outputs are unchanged throughout.
- REQ-035 SHALL pass this scenario: with IF_STATIC_PREDICT_EN, JAL imm=+0x40 fetched at 0x8 -> next fetch address 0x48; without the macro the next fetch address is 0xC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: pc register, icache address drive and a small in-order fetch queue.
// Optional JAL taken-prediction is enabled with `define IF_STATIC_PREDICT_EN.
module instruction_fetch #(
   parameter int unsigned QueueDepth = 4,
   parameter logic [31:0] ResetPC    = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   output logic [31:0] if_icache_inst_addr_out,
   input  logic        icache_if_miss_in,
   input  logic [31:0] icache_if_inst_inst_in,
   output logic        if_dec_valid_out,
   output logic [31:0] if_dec_inst_out,
   output logic [31:0] if_dec_pc_out,
   input  logic        dec_if_ready_in,
   input  logic        rob_if_jump_en_in,
   input  logic [31:0] rob_if_jump_addr_in
);

   localparam int unsigned PtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] Full = CntW'(QueueDepth);

   logic [31:0]     pc_q, pc_d, pc_next;
   logic [PtrW-1:0] head_q, head_d;
   logic [PtrW-1:0] tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;
   logic [31:0]     inst_mem [QueueDepth];
   logic [31:0]     pc_mem   [QueueDepth];
   logic            enq, deq;

   assign if_icache_inst_addr_out = pc_q;
   assign if_dec_valid_out        = (count_q != '0);
   assign if_dec_inst_out         = inst_mem[head_q];
   assign if_dec_pc_out           = pc_mem[head_q];

   // Full check uses the registered count, so a same-cycle dequeue cannot free a slot.
   assign enq = rdy_in & ~icache_if_miss_in & (count_q != Full) & ~rob_if_jump_en_in;
   assign deq = rdy_in & if_dec_valid_out & dec_if_ready_in & ~rob_if_jump_en_in;

`ifdef IF_STATIC_PREDICT_EN
   localparam logic [6:0] OpJal = 7'b1101111;

   logic [31:0] j_imm;

   always_comb begin
      j_imm = {{11{icache_if_inst_inst_in[31]}}, icache_if_inst_inst_in[31],
               icache_if_inst_inst_in[19:12], icache_if_inst_inst_in[20],
               icache_if_inst_inst_in[30:21], 1'b0};
      if (icache_if_inst_inst_in[6:0] == OpJal) begin
         pc_next = pc_q + j_imm;
      end else begin
         pc_next = pc_q + 32'd4;
      end
   end
`else
   assign pc_next = pc_q + 32'd4;
`endif

   always_comb begin
      pc_d    = pc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rdy_in) begin
         if (rob_if_jump_en_in) begin
            // Redirect flushes the queue and overrides any fetch or dequeue this cycle.
            pc_d    = rob_if_jump_addr_in;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            if (enq) begin
               pc_d   = pc_next;
               tail_d = tail_q + PtrW'(1);
            end
            if (deq) begin
               head_d = head_q + PtrW'(1);
            end
            unique case ({enq, deq})
               2'b10:   count_d = count_q + CntW'(1);
               2'b01:   count_d = count_q - CntW'(1);
               default: count_d = count_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pc_q    <= ResetPC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         pc_q    <= pc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Queue payload is not reset; it is only observable once count is non-zero.
   always_ff @(posedge clk_in) begin
      if (enq) begin
         inst_mem[tail_q] <= icache_if_inst_inst_in;
         pc_mem[tail_q]   <= pc_q;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Table-driven bench for instruction_fetch: per-cycle vectors with expected post-edge outputs,
// plus asynchronous reset checks between groups.
module tb_instruction_fetch;

   typedef struct {
      bit          rst;
      bit          rdy;
      bit          miss;
      bit          dec;
      bit          jmp;
      logic [31:0] jaddr;
      bit          jal;
      bit          ev;
      logic [31:0] eaddr;
      logic [31:0] ehpc;
   } vec_t;

`ifdef IF_STATIC_PREDICT_EN
   localparam bit Pred = 1'b1;
`else
   localparam bit Pred = 1'b0;
`endif
   localparam logic [31:0] JalWord = 32'h0400_00EF;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic [31:0] if_icache_inst_addr_out;
   logic        icache_if_miss_in = 1'b1;
   logic [31:0] icache_if_inst_inst_in;
   logic        if_dec_valid_out;
   logic [31:0] if_dec_inst_out;
   logic [31:0] if_dec_pc_out;
   logic        dec_if_ready_in = 1'b0;
   logic        rob_if_jump_en_in = 1'b0;
   logic [31:0] rob_if_jump_addr_in = 32'h0;
   bit          jal_on = 1'b0;

   int n_pass = 0;
   int n_total = 0;
   vec_t vecs[$];

   instruction_fetch #(
      .QueueDepth(4),
      .ResetPC   (32'h0)
   ) dut (
      .clk_in                 (clk_in),
      .rst_n_in               (rst_n_in),
      .rdy_in                 (rdy_in),
      .if_icache_inst_addr_out(if_icache_inst_addr_out),
      .icache_if_miss_in      (icache_if_miss_in),
      .icache_if_inst_inst_in (icache_if_inst_inst_in),
      .if_dec_valid_out       (if_dec_valid_out),
      .if_dec_inst_out        (if_dec_inst_out),
      .if_dec_pc_out          (if_dec_pc_out),
      .dec_if_ready_in        (dec_if_ready_in),
      .rob_if_jump_en_in      (rob_if_jump_en_in),
      .rob_if_jump_addr_in    (rob_if_jump_addr_in)
   );

   always #5 clk_in = ~clk_in;

   // Icache model: an addi-style word tagged with its address, or a JAL +0x40 at 0x8.
   function automatic logic [31:0] icache_word(logic [31:0] addr, bit jal);
      if (jal && addr == 32'h8) return JalWord;
      return {addr[24:0], 7'b0010011};
   endfunction

   assign icache_if_inst_inst_in = icache_word(if_icache_inst_addr_out, jal_on);

   function automatic vec_t mk(bit rst, bit rdy, bit miss, bit dec, bit jmp, logic [31:0] jaddr,
                               bit jal, bit ev, logic [31:0] eaddr, logic [31:0] ehpc);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.miss = miss; v.dec = dec; v.jmp = jmp; v.jaddr = jaddr;
      v.jal = jal; v.ev = ev; v.eaddr = eaddr; v.ehpc = ehpc;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   // Asynchronous reset: outputs must clear without any clock edge.
   task automatic do_reset(int idx);
      @(negedge clk_in);
      #2 rst_n_in = 1'b0;
      #1;
      check($sformatf("v%0d rst valid", idx), {31'b0, if_dec_valid_out}, 32'h0);
      check($sformatf("v%0d rst addr", idx), if_icache_inst_addr_out, 32'h0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
   endtask

   initial begin
      // REQ-030: hits with decoder ready
      vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 32'h4, 32'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 32'h8, 32'h4));
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 32'hC, 32'h8));
      // REQ-031: decoder stalled, queue fills at 4, pc stalls at 0x10
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 32'h4, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h8, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 32'hC, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h10, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h10, 32'h0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h10, 32'h0));
      // Full queue: dequeue does not allow a same-cycle enqueue
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 32'h10, 32'h4));
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 32'h14, 32'h8));
      // REQ-034: rdy low freezes everything, including a redirect request
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h14, 32'h8));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h14, 32'h8));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h200, 0, 1, 32'h14, 32'h8));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h14, 32'h8));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h14, 32'h8));
      // REQ-033: redirect with 3 entries queued and a same-cycle hit
      vecs.push_back(mk(0, 1, 0, 1, 1, 32'h100, 0, 0, 32'h100, 32'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 32'h104, 32'h100));
      // REQ-032: miss held 10 cycles at 0x20
      vecs.push_back(mk(0, 1, 0, 1, 1, 32'h20, 0, 0, 32'h20, 32'h0));
      for (int k = 0; k < 10; k++) vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 32'h20, 32'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 32'h24, 32'h20));
      // REQ-023: redirect during a miss moves pc at once
      vecs.push_back(mk(0, 1, 1, 1, 1, 32'h40, 0, 0, 32'h40, 32'h0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 32'h40, 32'h0));
      // REQ-035: JAL +0x40 at 0x8
      vecs.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 32'h4, 32'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 1, 32'h8, 32'h4));
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 1, Pred ? 32'h48 : 32'hC, 32'h8));
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 1, Pred ? 32'h4C : 32'h10, Pred ? 32'h48 : 32'hC));
      // REQ-024: pc wraps from 0xFFFFFFFC to 0
      vecs.push_back(mk(0, 1, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC));

      // Initial reset state, held asynchronously before any edge matters
      #1;
      check("init valid", {31'b0, if_dec_valid_out}, 32'h0);
      check("init addr", if_icache_inst_addr_out, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset(i);
         rdy_in              = vecs[i].rdy;
         icache_if_miss_in   = vecs[i].miss;
         dec_if_ready_in     = vecs[i].dec;
         rob_if_jump_en_in   = vecs[i].jmp;
         rob_if_jump_addr_in = vecs[i].jaddr;
         jal_on              = vecs[i].jal;
         @(posedge clk_in);
         #1;
         check($sformatf("v%0d valid", i), {31'b0, if_dec_valid_out}, {31'b0, vecs[i].ev});
         check($sformatf("v%0d addr", i), if_icache_inst_addr_out, vecs[i].eaddr);
         if (vecs[i].ev) begin
            check($sformatf("v%0d head pc", i), if_dec_pc_out, vecs[i].ehpc);
            check($sformatf("v%0d head inst", i), if_dec_inst_out,
                  icache_word(vecs[i].ehpc, vecs[i].jal));
         end
      end

      // Mid-stream asynchronous reset with a non-empty queue
      rdy_in = 1'b1; icache_if_miss_in = 1'b0; dec_if_ready_in = 1'b0; rob_if_jump_en_in = 1'b0;
      @(posedge clk_in);
      @(posedge clk_in);
      do_reset(999);
      @(posedge clk_in);
      #1;
      check("post-rst fetch addr", if_icache_inst_addr_out, 32'h4);
      check("post-rst head pc", if_dec_pc_out, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
